demux1to4_tdm: RTL and testbench

//  Receive-side partner of the 4:1 select mux tree: a time-division 1:4 demultiplexer.

---
 rtl/demux1to4_tdm_if.sv | 27 ++
 rtl/demux1to4_tdm.sv | 70 +++++++
 tb/tb_demux1to4_tdm.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux1to4_tdm_if.sv
// Bus between the serial sample source and the 1:4 TDM demultiplexer.
interface demux1to4_tdm_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0] z;
  logic         valid;
  logic         sync;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         frame_valid;
  logic [1:0]   sel;
  logic         err;

  // Sample source side: drives the serial lane, observes the frame.
  modport master (
    output z, valid, sync,
    input  a, b, c, d, frame_valid, sel, err
  );

  // Demultiplexer side.
  modport slave (
    input  z, valid, sync,
    output a, b, c, d, frame_valid, sel, err
  );
endinterface

// File: rtl/demux1to4_tdm.sv
// Time-division 1:4 demultiplexer: collects four serial samples into slots A..D
// and presents them as one registered frame with a single-cycle strobe.
module demux1to4_tdm #(
  parameter int unsigned W = 1
) (
  input logic            clk,
  input logic            rst,
  demux1to4_tdm_if.slave bus
);

  logic [1:0]   sel_q;
  logic [W-1:0] s0_q, s1_q, s2_q;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic         frame_valid_q;
  logic         err_q;

  // Slot counter, shadow capture, frame publish and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q         <= 2'd0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      if (bus.valid) begin
        if (bus.sync) begin
          // A sync sample always starts a new frame; anything collected so far is dropped.
          s0_q  <= bus.z;
          sel_q <= 2'd1;
          err_q <= (sel_q != 2'd0);
        end else begin
          unique case (sel_q)
            2'd0: s0_q <= bus.z;
            2'd1: s1_q <= bus.z;
            2'd2: s2_q <= bus.z;
            2'd3: begin
              a_q           <= s0_q;
              b_q           <= s1_q;
              c_q           <= s2_q;
              d_q           <= bus.z;
              frame_valid_q <= 1'b1;
            end
            default: ;
          endcase
          sel_q <= sel_q + 2'd1;
        end
      end
    end
  end

  // Registered state straight onto the bus.
  always_comb begin
    bus.a           = a_q;
    bus.b           = b_q;
    bus.c           = c_q;
    bus.d           = d_q;
    bus.frame_valid = frame_valid_q;
    bus.sel         = sel_q;
    bus.err         = err_q;
  end

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Self-checking bench for demux1to4_tdm: directed scenarios plus a randomized run,
// all compared against a queue-based frame assembler model.
module tb_demux1to4_tdm;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  demux1to4_tdm_if #(.W(W)) bus ();

  demux1to4_tdm #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned total;
  int unsigned passed;

  // Model: samples of the frame being assembled, plus the last published frame.
  logic [W-1:0] pend[$];
  logic [W-1:0] exp_a, exp_b, exp_c, exp_d;
  logic         exp_fv, exp_err;
  logic [1:0]   exp_sel;

  logic [4*W+3:0] got, want;

  // Drive one cycle, wait past the edge, then advance the model.
  task automatic cycle(input logic r, input logic [W-1:0] zz, input logic v, input logic sy);
    rst       = r;
    bus.z     = zz;
    bus.valid = v;
    bus.sync  = sy;
    @(posedge clk);
    #1;
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      pend.delete();
      exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    end else if (v) begin
      if (sy) begin
        exp_err = (pend.size() != 0);
        pend.delete();
        pend.push_back(zz);
      end else begin
        pend.push_back(zz);
        if (pend.size() == 4) begin
          exp_a  = pend[0];
          exp_b  = pend[1];
          exp_c  = pend[2];
          exp_d  = pend[3];
          exp_fv = 1'b1;
          pend.delete();
        end
      end
    end
    exp_sel = 2'(pend.size());
    got  = {bus.a, bus.b, bus.c, bus.d, bus.sel, bus.frame_valid, bus.err};
    want = {exp_a, exp_b, exp_c, exp_d, exp_sel, exp_fv, exp_err};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, W'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (got !== {(4*W+4){1'b0}}) $display("FAIL reset cyc%0d got=%h want=0", i, got);
      else passed++;
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] zs[4];
    zs = '{8'd1, 8'd0, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, zs[i], 1'b1, 1'b0);
      total++;
      if (got !== want) $display("FAIL frame cyc%0d got=%h want=%h", i, got, want);
      else passed++;
    end
    total++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.sel} !== {32'h01000101, 1'b1, 2'd0})
      $display("FAIL frame_out got=%h%h%h%h fv=%b sel=%0d want=01000101 fv=1 sel=0",
               bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.sel);
    else passed++;
    cycle(1'b0, 8'hff, 1'b0, 1'b0);
    total++;
    if (bus.frame_valid !== 1'b0 || bus.a !== 8'h01)
      $display("FAIL frame_pulse fv=%b a=%h want fv=0 a=01", bus.frame_valid, bus.a);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [1:0] sels[4];
    sels = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, W'(8'h11 * (i + 1)), 1'b1, 1'b0);
      total++;
      if (got !== want || bus.sel !== sels[i])
        $display("FAIL gaps_valid cyc%0d got=%h want=%h sel want=%0d", i, got, want, sels[i]);
      else passed++;
      if (i < 3) begin
        cycle(1'b0, W'($urandom), 1'b0, 1'($urandom));
        total++;
        if (got !== want || bus.sel !== sels[i])
          $display("FAIL gaps_idle cyc%0d got=%h want=%h", i, got, want);
        else passed++;
      end
    end
    total++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 32'h11223344 || bus.frame_valid !== 1'b1)
      $display("FAIL gaps_frame got=%h%h%h%h fv=%b want=11223344 fv=1",
               bus.a, bus.b, bus.c, bus.d, bus.frame_valid);
    else passed++;
  endtask

  task automatic test_sync_err();
    logic [W-1:0] zs[6];
    logic         sy[6];
    zs = '{8'haa, 8'hbb, 8'h01, 8'h02, 8'h03, 8'h04};
    sy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, zs[i], 1'b1, sy[i]);
      total++;
      if (got !== want) $display("FAIL sync_err cyc%0d got=%h want=%h", i, got, want);
      else passed++;
      if (i == 2) begin
        total++;
        if (bus.err !== 1'b1 || bus.sel !== 2'd1 || bus.a !== 8'h11)
          $display("FAIL sync_err_pulse err=%b sel=%0d a=%h want err=1 sel=1 a=11",
                   bus.err, bus.sel, bus.a);
        else passed++;
      end
    end
    total++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 32'h01020304 || bus.frame_valid !== 1'b1)
      $display("FAIL sync_frame got=%h%h%h%h want=01020304", bus.a, bus.b, bus.c, bus.d);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int errs = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, W'(8'hc0 + i), 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    if (bus.err) errs++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, W'(5 + i), 1'b1, 1'b0);
      if (bus.err) errs++;
      total++;
      if (got !== want) $display("FAIL rst_mid cyc%0d got=%h want=%h", i, got, want);
      else passed++;
    end
    total++;
    if (errs != 0 || {bus.a, bus.b, bus.c, bus.d} !== 32'h05060708)
      $display("FAIL rst_mid_frame errs=%0d got=%h%h%h%h want errs=0 05060708",
               errs, bus.a, bus.b, bus.c, bus.d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int fv_at[$];
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, W'(i + 1), 1'b1, 1'b0);
      if (bus.frame_valid) fv_at.push_back(i);
      total++;
      if (got !== want) $display("FAIL b2b cyc%0d got=%h want=%h", i, got, want);
      else passed++;
      if (i == 3) begin
        total++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 32'h01020304)
          $display("FAIL b2b_first got=%h%h%h%h want=01020304", bus.a, bus.b, bus.c, bus.d);
        else passed++;
      end
    end
    total++;
    if (fv_at.size() != 2 || fv_at[0] != 3 || fv_at[1] != 7 ||
        {bus.a, bus.b, bus.c, bus.d} !== 32'h05060708)
      $display("FAIL b2b_strobes count=%0d got=%h%h%h%h want count=2 at 3,7 05060708",
               fv_at.size(), bus.a, bus.b, bus.c, bus.d);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
      total++;
      if (got !== want) $display("FAIL random cyc%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    bus.z     = '0;
    bus.valid = 1'b0;
    bus.sync  = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    exp_fv = 1'b0; exp_err = 1'b0; exp_sel = 2'd0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_gaps();
    test_sync_err();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
